link_table_order_arbiter: RTL and testbench
===========================================

Name: link_table_order_arbiter

Overview:
Shares one link_table_mamager order/response port between REQ_NUM requesters using round-robin arbitration.
Only one order is outstanding at a time. The block takes a requester's order, issues it to the manager, waits for the manager's dout response, and returns that response to the requester that issued the order.
Also keeps saturating counters of completed orders and of failed (fatal) non-READ orders.

Parameters:
REQ_NUM, 4, number of requesters (2..8)
ADDR_WIDTH, 16, node index width (matches manager)
DATA_WIDTH, 16, data width (matches manager)
TABLE_WIDTH, 8, table index width (matches manager)
CNT_WIDTH, 16, width of statistics counters

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
req_valid  in  REQ_NUM  order valid, one bit per requester
req_busy  out  REQ_NUM  order busy, one bit per requester
req_type  in  2*REQ_NUM  order type per requester; slice i = bits [2i+1:2i]; 00 APPE, 01 DELE, 10 CHAG, 11 READ
req_table  in  TABLE_WIDTH*REQ_NUM  table index per requester
req_node  in  ADDR_WIDTH*REQ_NUM  node index per requester
req_data  in  DATA_WIDTH*REQ_NUM  write data per requester
rsp_valid  out  REQ_NUM  response valid; only the owner's bit is ever high
rsp_busy  in  REQ_NUM  response back-pressure per requester
rsp_data  out  DATA_WIDTH  response data, shared by all requesters
mgr_order_valid  out  1  to manager order_valid
mgr_order_busy  in  1  from manager order_busy
mgr_order_type  out  2  latched order type
mgr_order_table  out  TABLE_WIDTH  latched table index
mgr_order_node  out  ADDR_WIDTH  latched node index
mgr_order_data  out  DATA_WIDTH  latched write data
mgr_dout_valid  in  1  from manager dout_valid
mgr_dout_busy  out  1  to manager dout_busy
mgr_dout_data  in  DATA_WIDTH  from manager dout_data
grant_id  out  $clog2(REQ_NUM)  current or last owner
done_count  out  CNT_WIDTH  completed orders, saturating
fail_count  out  CNT_WIDTH  non-READ orders that returned 0, saturating

Behaviour:
- Handshake rule on every interface: a transfer occurs when valid && !busy in the same cycle.
- Reset (rst high at a clk edge):
  - state=IDLE, rr_ptr=0, grant_id=0.
  - mgr_order_valid=0, all rsp_valid=0.
  - rsp_data=0, all latched mgr_order_* fields=0.
  - Both counters=0.
  - Reset mid-operation drops the in-flight order without a response. The manager must be reset in the same cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i], searching from rr_ptr upward and wrapping modulo REQ_NUM.
  - req_busy[winner]=0 (combinational). All other req_busy bits=1. In all other states every req_busy bit=1.
  - On the accept cycle: latch type/table/node/data from the winner's slice, grant_id<=winner, mgr_order_valid<=1, go to ISSUE.
- ISSUE:
  - mgr_order_valid held high and fields held stable until mgr_order_valid && !mgr_order_busy.
  - Then mgr_order_valid<=0 and go to WAIT.
  - mgr_order_valid is therefore high for exactly the handshake cycle plus any stall cycles.
- WAIT:
  - mgr_dout_busy=0 (combinational). In all other states mgr_dout_busy=1.
  - On mgr_dout_valid: rsp_data<=mgr_dout_data, rsp_valid[grant_id]<=1, go to RESP.
- RESP:
  - rsp_valid[grant_id] held until !rsp_busy[grant_id].
  - Then rsp_valid<=0, rr_ptr<=(grant_id+1) mod REQ_NUM, go to IDLE.
  - done_count+1 on that cycle.
  - fail_count+1 on that cycle if latched type!=READ and rsp_data==0.
  - Both counters saturate at all-ones.
- Latency:
  - Order accepted at cycle T → mgr_order_valid high at T+1.
  - dout accepted at cycle D → rsp_valid high at D+1.
  - Response accepted at R → earliest next accept at R+1.
- Order of a single requester's orders is preserved; orders never overlap.
- req_* inputs are ignored outside the accept cycle. A requester may change its fields freely while busy.
- mgr_dout_valid asserted outside WAIT is not consumed and stays pending until WAIT (busy=1).
- rr_ptr wrap: grant_id=REQ_NUM-1 → rr_ptr=0.
- Non-power-of-2 REQ_NUM: grant_id indexes 0..REQ_NUM-1 only.

Test Plan:
1. Single requester: req_valid=0001, type=READ, table=3, node=2; manager returns 0x00AB → mgr_order_* = {11,3,2}; rsp_valid=0001 with rsp_data=0x00AB one cycle after dout accepted; done_count=1, fail_count=0.
2. All four requesters valid continuously, each issuing CHAG → grant sequence 0,1,2,3,0; no rsp_valid bit ever set for a non-owner; done_count=5.
3. mgr_order_busy held high for 3 cycles in ISSUE → mgr_order_valid high 4 cycles with fields unchanged; exactly one order reaches the manager.
4. APPE returning dout_data=0 (fatal), then DELE returning 1, then READ returning 0 → fail_count=1, done_count=3.
5. Requester 2 holds rsp_busy=1 for 5 cycles → rsp_valid[2] held; req_valid[0]=1 stays unaccepted (req_busy=1111) until the response completes; then grant goes to requester 3 if valid, else 0.
6. rst pulsed while in WAIT → next cycle: state IDLE, mgr_order_valid=0, rsp_valid=0, counters=0, rr_ptr=0; a new request from requester 1 is accepted normally.

Source files
------------

// File: rtl/link_table_order_arbiter_if.sv
// Requester-side and manager-side buses of the link table order arbiter.
// slave is the arbiter's view; master is the surrounding requesters and manager.
interface link_table_order_arbiter_if #(
    parameter int REQ_NUM     = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int TABLE_WIDTH = 8
);
    logic [REQ_NUM-1:0]             req_valid;
    logic [REQ_NUM-1:0]             req_busy;
    logic [2*REQ_NUM-1:0]           req_type;
    logic [TABLE_WIDTH*REQ_NUM-1:0] req_table;
    logic [ADDR_WIDTH*REQ_NUM-1:0]  req_node;
    logic [DATA_WIDTH*REQ_NUM-1:0]  req_data;
    logic [REQ_NUM-1:0]             rsp_valid;
    logic [REQ_NUM-1:0]             rsp_busy;
    logic [DATA_WIDTH-1:0]          rsp_data;
    logic                           mgr_order_valid;
    logic                           mgr_order_busy;
    logic [1:0]                     mgr_order_type;
    logic [TABLE_WIDTH-1:0]         mgr_order_table;
    logic [ADDR_WIDTH-1:0]          mgr_order_node;
    logic [DATA_WIDTH-1:0]          mgr_order_data;
    logic                           mgr_dout_valid;
    logic                           mgr_dout_busy;
    logic [DATA_WIDTH-1:0]          mgr_dout_data;

    modport slave (
        input  req_valid, req_type, req_table, req_node, req_data,
        output req_busy,
        output rsp_valid, rsp_data,
        input  rsp_busy,
        output mgr_order_valid, mgr_order_type, mgr_order_table,
        output mgr_order_node, mgr_order_data,
        input  mgr_order_busy,
        input  mgr_dout_valid, mgr_dout_data,
        output mgr_dout_busy
    );

    modport master (
        output req_valid, req_type, req_table, req_node, req_data,
        input  req_busy,
        input  rsp_valid, rsp_data,
        output rsp_busy,
        input  mgr_order_valid, mgr_order_type, mgr_order_table,
        input  mgr_order_node, mgr_order_data,
        output mgr_order_busy,
        output mgr_dout_valid, mgr_dout_data,
        input  mgr_dout_busy
    );
endinterface

// File: rtl/link_table_order_arbiter.sv
// Round-robin sharing of one link table manager order port between requesters,
// one order in flight, with saturating done/fail statistics.
module link_table_order_arbiter #(
    parameter int REQ_NUM     = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int TABLE_WIDTH = 8,
    parameter int CNT_WIDTH   = 16,
    localparam int GW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    link_table_order_arbiter_if.slave bus,
    output logic [GW-1:0]        grant_id,
    output logic [CNT_WIDTH-1:0] done_count,
    output logic [CNT_WIDTH-1:0] fail_count
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;
    localparam logic [1:0] READ  = 2'b11;

    logic [1:0]             state;
    logic [GW-1:0]          rr_ptr;
    logic [GW-1:0]          idx;
    logic [GW-1:0]          winner;
    logic                   found;
    logic [REQ_NUM-1:0]     win_oh;
    logic [REQ_NUM-1:0]     grant_oh;
    logic                   own_busy;
    logic [1:0]             sel_type;
    logic [TABLE_WIDTH-1:0] sel_table;
    logic [ADDR_WIDTH-1:0]  sel_node;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   accept;
    logic                   rsp_done;

    // Search from rr_ptr upward, wrapping, so the last owner goes to the back.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            idx = GW'((int'(rr_ptr) + k) % REQ_NUM);
            if (!found && |(bus.req_valid & (REQ_NUM'(1) << idx))) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        win_oh    = '0;
        grant_oh  = '0;
        sel_type  = '0;
        sel_table = '0;
        sel_node  = '0;
        sel_data  = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            win_oh[i]   = (winner == GW'(i));
            grant_oh[i] = (grant_id == GW'(i));
            if (winner == GW'(i)) begin
                sel_type  = bus.req_type[i*2 +: 2];
                sel_table = bus.req_table[i*TABLE_WIDTH +: TABLE_WIDTH];
                sel_node  = bus.req_node[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign accept        = (state == IDLE) && found;
    assign bus.req_busy  = accept ? ~win_oh : '1;
    assign bus.mgr_dout_busy = (state != WAIT);
    assign own_busy      = |(bus.rsp_busy & grant_oh);
    assign rsp_done      = (state == RESP) && !own_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            rr_ptr              <= '0;
            grant_id            <= '0;
            bus.mgr_order_valid <= 1'b0;
            bus.mgr_order_type  <= '0;
            bus.mgr_order_table <= '0;
            bus.mgr_order_node  <= '0;
            bus.mgr_order_data  <= '0;
            bus.rsp_valid       <= '0;
            bus.rsp_data        <= '0;
            done_count          <= '0;
            fail_count          <= '0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    bus.mgr_order_type  <= sel_type;
                    bus.mgr_order_table <= sel_table;
                    bus.mgr_order_node  <= sel_node;
                    bus.mgr_order_data  <= sel_data;
                    grant_id            <= winner;
                    bus.mgr_order_valid <= 1'b1;
                    state               <= ISSUE;
                end
                ISSUE: if (!bus.mgr_order_busy) begin
                    bus.mgr_order_valid <= 1'b0;
                    state               <= WAIT;
                end
                WAIT: if (bus.mgr_dout_valid) begin
                    bus.rsp_data  <= bus.mgr_dout_data;
                    bus.rsp_valid <= grant_oh;
                    state         <= RESP;
                end
                RESP: if (rsp_done) begin
                    bus.rsp_valid <= '0;
                    rr_ptr        <= (grant_id == GW'(REQ_NUM - 1)) ? '0 : grant_id + 1'b1;
                    state         <= IDLE;
                    if (done_count != '1)
                        done_count <= done_count + 1'b1;
                    // A zero reply to a write-type order means the manager hit a fatal case.
                    if (bus.mgr_order_type != READ && bus.rsp_data == '0 && fail_count != '1)
                        fail_count <= fail_count + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_link_table_order_arbiter.sv
// Directed bench for link_table_order_arbiter: transaction vector table plus
// hand sequences for manager stall, response back-pressure and mid-order reset.
module tb_link_table_order_arbiter;
    localparam int N = 4;

    logic clk;
    logic rst;
    logic [1:0]  grant_id;
    logic [15:0] done_count;
    logic [15:0] fail_count;

    int checks = 0;
    int errors = 0;

    link_table_order_arbiter_if #(.REQ_NUM(N)) bus ();

    link_table_order_arbiter #(.REQ_NUM(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .grant_id   (grant_id),
        .done_count (done_count),
        .fail_count (fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst_before;
        logic [3:0]  valid;
        logic [7:0]  types;
        logic [15:0] dout;
        int          grant;
        int          done;
        int          fail;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [7:0] tbl_of(input int i);
        return 8'(3 + 16 * i);
    endfunction

    function automatic logic [15:0] node_of(input int i);
        return 16'(2 + 256 * i);
    endfunction

    function automatic logic [15:0] data_of(input int i);
        return 16'(32'hD000 + i);
    endfunction

    task automatic run_txn(input vec_t v);
        logic [3:0] exp_busy;
        logic [3:0] exp_rsp;
        logic [7:0] t;
        t = v.types;
        if (v.rst_before) do_reset();
        bus.req_valid = v.valid;
        bus.req_type  = v.types;
        #1;
        exp_busy = 4'b1111;
        exp_busy[v.grant] = 1'b0;
        chk("req_busy_idle", 32'(bus.req_busy), 32'(exp_busy));
        tick();
        chk("order_valid_up", 32'(bus.mgr_order_valid), 32'd1);
        chk("grant_id", 32'(grant_id), 32'(v.grant));
        chk("order_type", 32'(bus.mgr_order_type), 32'(t[2*v.grant +: 2]));
        chk("order_table", 32'(bus.mgr_order_table), 32'(tbl_of(v.grant)));
        chk("order_node", 32'(bus.mgr_order_node), 32'(node_of(v.grant)));
        chk("order_data", 32'(bus.mgr_order_data), 32'(data_of(v.grant)));
        bus.req_valid = '0;
        tick();
        chk("order_valid_down", 32'(bus.mgr_order_valid), 32'd0);
        chk("dout_busy_wait", 32'(bus.mgr_dout_busy), 32'd0);
        chk("req_busy_wait", 32'(bus.req_busy), 32'hF);
        bus.mgr_dout_valid = 1'b1;
        bus.mgr_dout_data  = v.dout;
        tick();
        bus.mgr_dout_valid = 1'b0;
        exp_rsp = 4'b0000;
        exp_rsp[v.grant] = 1'b1;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp));
        chk("rsp_data", 32'(bus.rsp_data), 32'(v.dout));
        tick();
        chk("rsp_valid_clear", 32'(bus.rsp_valid), 32'd0);
        chk("done_count", 32'(done_count), 32'(v.done));
        chk("fail_count", 32'(fail_count), 32'(v.fail));
    endtask

    initial begin
        rst                = 1'b1;
        bus.req_valid      = '0;
        bus.req_type       = '0;
        bus.rsp_busy       = '0;
        bus.mgr_order_busy = 1'b0;
        bus.mgr_dout_valid = 1'b0;
        bus.mgr_dout_data  = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_table[i*8 +: 8]   = tbl_of(i);
            bus.req_node[i*16 +: 16]  = node_of(i);
            bus.req_data[i*16 +: 16]  = data_of(i);
        end

        // rst, valid, types, dout, grant, done, fail
        vecs.push_back('{0, 4'b0001, 8'hFF, 16'h00AB, 0, 1, 0});
        vecs.push_back('{1, 4'b1111, 8'hAA, 16'h0101, 0, 1, 0});
        vecs.push_back('{0, 4'b1111, 8'hAA, 16'h0102, 1, 2, 0});
        vecs.push_back('{0, 4'b1111, 8'hAA, 16'h0103, 2, 3, 0});
        vecs.push_back('{0, 4'b1111, 8'hAA, 16'h0104, 3, 4, 0});
        vecs.push_back('{0, 4'b1111, 8'hAA, 16'h0105, 0, 5, 0});
        vecs.push_back('{1, 4'b0001, 8'h00, 16'h0000, 0, 1, 1});
        vecs.push_back('{0, 4'b0010, 8'h55, 16'h0001, 1, 2, 1});
        vecs.push_back('{0, 4'b0100, 8'hFF, 16'h0000, 2, 3, 1});
        vecs.push_back('{0, 4'b1001, 8'hAA, 16'h0077, 3, 4, 1});
        vecs.push_back('{0, 4'b0110, 8'hAA, 16'h0088, 1, 5, 1});

        tick();
        tick();
        rst = 1'b0;
        chk("rst_order_valid", 32'(bus.mgr_order_valid), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_order_fields", {bus.mgr_order_type, bus.mgr_order_table,
            bus.mgr_order_node[5:0], bus.mgr_order_data[15:0]}, 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_counts", {done_count, fail_count}, 32'd0);
        chk("rst_dout_busy", 32'(bus.mgr_dout_busy), 32'd1);

        foreach (vecs[k]) run_txn(vecs[k]);

        // Manager holds order_busy for three cycles; rr_ptr is 2 here.
        bus.req_valid      = 4'b0100;
        bus.req_type       = 8'hAA;
        bus.mgr_order_busy = 1'b1;
        #1;
        chk("stall_req_busy", 32'(bus.req_busy), 32'hB);
        tick();
        bus.req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            chk("stall_valid", 32'(bus.mgr_order_valid), 32'd1);
            chk("stall_fields", {bus.mgr_order_type, bus.mgr_order_table,
                bus.mgr_order_node[5:0], bus.mgr_order_data},
                {2'b10, tbl_of(2), node_of(2)[5:0], data_of(2)});
            if (c < 3) tick();
        end
        bus.mgr_order_busy = 1'b0;
        tick();
        chk("stall_released", 32'(bus.mgr_order_valid), 32'd0);
        tick();
        chk("stall_single_order", 32'(bus.mgr_order_valid), 32'd0);
        bus.mgr_dout_valid = 1'b1;
        bus.mgr_dout_data  = 16'h0042;
        tick();
        bus.mgr_dout_valid = 1'b0;
        chk("stall_rsp", 32'(bus.rsp_valid), 32'h4);
        tick();
        chk("stall_done", 32'(done_count), 32'd6);
        chk("stall_fail", 32'(fail_count), 32'd1);

        // Requester 2 back-pressures its response for five cycles.
        do_reset();
        bus.req_valid = 4'b0100;
        bus.req_type  = 8'hFF;
        #1;
        chk("bp_req_busy", 32'(bus.req_busy), 32'hB);
        tick();
        bus.req_valid = 4'b1001;
        tick();
        bus.mgr_dout_valid = 1'b1;
        bus.mgr_dout_data  = 16'h0055;
        bus.rsp_busy       = 4'b0100;
        tick();
        bus.mgr_dout_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_held", 32'(bus.rsp_valid), 32'h4);
            chk("bp_req_blocked", 32'(bus.req_busy), 32'hF);
            tick();
        end
        bus.rsp_busy = '0;
        tick();
        chk("bp_rsp_clear", 32'(bus.rsp_valid), 32'd0);
        chk("bp_done", 32'(done_count), 32'd1);
        chk("bp_next_winner", 32'(bus.req_busy), 32'h7);
        tick();
        chk("bp_grant3", 32'(grant_id), 32'd3);
        chk("bp_issue", 32'(bus.mgr_order_valid), 32'd1);
        bus.req_valid = '0;
        tick();
        chk("bp_in_wait", 32'(bus.mgr_dout_busy), 32'd0);

        // Reset while waiting for the manager's reply.
        do_reset();
        chk("wrst_order_valid", 32'(bus.mgr_order_valid), 32'd0);
        chk("wrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("wrst_counts", {done_count, fail_count}, 32'd0);
        chk("wrst_grant", 32'(grant_id), 32'd0);
        chk("wrst_dout_busy", 32'(bus.mgr_dout_busy), 32'd1);
        run_txn('{0, 4'b0010, 8'hFF, 16'h1234, 1, 1, 0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
